pc_seq_ctrl: RTL and testbench

// - Instruction-cycle sequencer that drives the LC-3 program counter and fetch path.
// - Issues ldPC/selPC and the MAR/MDR/IR load and gate strobes for fetch.
// - Executes control-flow opcodes itself: BR, JMP/RET, JSR/JSRR, TRAP.
// - Hands every other opcode to the execute unit over a start/done handshake.

---
 rtl/pc_seq_ctrl_pkg.sv | 45 ++++
 rtl/pc_seq_ctrl_mem_wait_timer.sv | 42 ++++
 rtl/pc_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared LC-3 control encodings: opcodes, PC mux and EAB offset selects,
// and the bundle of strobes the sequencer decodes from its state.
package pc_seq_ctrl_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    SELPC_INC = 2'b00,
    SELPC_EAB = 2'b01,
    SELPC_BUS = 2'b10
  } selpc_e;

  typedef enum logic [1:0] {
    ADDR2_OFF9  = 2'b00,
    ADDR2_OFF11 = 2'b01,
    ADDR2_ZERO  = 2'b10
  } addr2_e;

  typedef struct packed {
    logic   ld_mar;
    logic   ld_mdr;
    logic   ld_ir;
    logic   ld_pc;
    logic   ld_r7;
    selpc_e sel_pc;
    addr2_e addr2_sel;
    logic   gate_pc;
    logic   gate_mdr;
    logic   gate_marmux;
    logic   gate_baser;
    logic   marmux_sel;
    logic   mem_en;
    logic   exec_start;
    logic   fault;
  } ctrl_t;

  // Branch enable: any requested condition code that is currently set.
  function automatic logic br_enable(input logic [2:0] cond, input logic [2:0] nzp);
    return |(cond & nzp);
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_mem_wait_timer.sv
// Counts consecutive cycles without mem_r while the sequencer waits on memory
// and flags the deadline cycle; a zero timeout disables the flag entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int BUSY_W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_r,
  output logic timeout
);

  logic [BUSY_W-1:0] count_q;
  logic [BUSY_W-1:0] count_d;

  // Outside a wait state the count is held at zero, so every entry starts clean.
  always_comb begin
    count_d = '0;
    if (waiting && !mem_r) begin
      count_d = count_q + BUSY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      localparam logic [BUSY_W-1:0] LIMIT = BUSY_W'(MEM_TIMEOUT - 1);
      assign timeout = waiting && !mem_r && (count_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/pc_seq_ctrl.sv
// LC-3 instruction-cycle sequencer: fetch, control-flow opcodes handled locally,
// everything else handed to the execute unit; memory waits guarded by a timer.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int BUSY_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_r,
  input  logic        exec_done,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        ldIR,
  output logic        ldPC,
  output logic        ldR7,
  output logic [1:0]  selPC,
  output logic [1:0]  addr2_sel,
  output logic        gatePC,
  output logic        gateMDR,
  output logic        gateMARMUX,
  output logic        gateBaseR,
  output logic        marmux_sel,
  output logic        memEN,
  output logic        exec_start,
  output logic        fault,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH1 = 4'd0,
    S_FETCH2 = 4'd1,
    S_FETCH3 = 4'd2,
    S_DECODE = 4'd3,
    S_BR     = 4'd4,
    S_JMP    = 4'd5,
    S_JSR    = 4'd6,
    S_JSR2   = 4'd7,
    S_TRAP1  = 4'd8,
    S_TRAP2  = 4'd9,
    S_TRAP3  = 4'd10,
    S_TRAP4  = 4'd11,
    S_EXEC   = 4'd12,
    S_FAULT  = 4'd13
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   exec_busy_q;
  logic   exec_busy_d;
  logic   mem_waiting;
  logic   mem_timeout;
  ctrl_t  ctrl;
  logic   unused_ir;

  assign unused_ir   = ^ir[8:0];
  assign mem_waiting = (state_q == S_FETCH2) || (state_q == S_TRAP3);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .BUSY_W     (BUSY_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(mem_waiting),
    .mem_r  (mem_r),
    .timeout(mem_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH1;
      exec_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exec_busy_q <= exec_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    exec_busy_d = 1'b0;
    case (state_q)
      S_FETCH1: if (run) state_d = S_FETCH2;
      S_FETCH2: begin
        if (mem_r)            state_d = S_FETCH3;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          OP_BR:   state_d = S_BR;
          OP_JMP:  state_d = S_JMP;
          OP_JSR:  state_d = S_JSR;
          OP_TRAP: state_d = S_TRAP1;
          default: state_d = S_EXEC;
        endcase
      end
      S_BR, S_JMP, S_JSR2, S_TRAP4: state_d = S_FETCH1;
      S_JSR:   state_d = S_JSR2;
      S_TRAP1: state_d = S_TRAP2;
      S_TRAP2: state_d = S_TRAP3;
      S_TRAP3: begin
        if (mem_r)            state_d = S_TRAP4;
        else if (mem_timeout) state_d = S_FAULT;
      end
      // exec_busy marks every cycle after the first, so exec_start is a single pulse.
      S_EXEC: begin
        if (exec_done) state_d = S_FETCH1;
        else           exec_busy_d = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH1;
    endcase
  end

  // Strobes are gated by reset so nothing is issued while it is held low.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state_q)
        S_FETCH1: begin
          if (run) begin
            ctrl.gate_pc = 1'b1;
            ctrl.ld_mar  = 1'b1;
            ctrl.ld_pc   = 1'b1;
            ctrl.sel_pc  = SELPC_INC;
          end
        end
        S_FETCH2, S_TRAP3: begin
          ctrl.mem_en = 1'b1;
          ctrl.ld_mdr = mem_r;
        end
        S_FETCH3: begin
          ctrl.gate_mdr = 1'b1;
          ctrl.ld_ir    = 1'b1;
        end
        S_BR: begin
          if (br_enable(ir[11:9], nzp)) begin
            ctrl.ld_pc     = 1'b1;
            ctrl.sel_pc    = SELPC_EAB;
            ctrl.addr2_sel = ADDR2_OFF9;
          end
        end
        S_JMP: begin
          ctrl.gate_baser = 1'b1;
          ctrl.ld_pc      = 1'b1;
          ctrl.sel_pc     = SELPC_BUS;
        end
        S_JSR, S_TRAP2: begin
          ctrl.gate_pc = 1'b1;
          ctrl.ld_r7   = 1'b1;
        end
        S_JSR2: begin
          ctrl.ld_pc = 1'b1;
          if (ir[11]) begin
            ctrl.sel_pc    = SELPC_EAB;
            ctrl.addr2_sel = ADDR2_OFF11;
          end else begin
            ctrl.gate_baser = 1'b1;
            ctrl.sel_pc     = SELPC_BUS;
            ctrl.addr2_sel  = ADDR2_ZERO;
          end
        end
        S_TRAP1: begin
          ctrl.gate_marmux = 1'b1;
          ctrl.marmux_sel  = 1'b1;
          ctrl.ld_mar      = 1'b1;
        end
        S_TRAP4: begin
          ctrl.gate_mdr = 1'b1;
          ctrl.ld_pc    = 1'b1;
          ctrl.sel_pc   = SELPC_BUS;
        end
        S_EXEC:  ctrl.exec_start = !exec_busy_q;
        S_FAULT: ctrl.fault      = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign ldMAR      = ctrl.ld_mar;
  assign ldMDR      = ctrl.ld_mdr;
  assign ldIR       = ctrl.ld_ir;
  assign ldPC       = ctrl.ld_pc;
  assign ldR7       = ctrl.ld_r7;
  assign selPC      = ctrl.sel_pc;
  assign addr2_sel  = ctrl.addr2_sel;
  assign gatePC     = ctrl.gate_pc;
  assign gateMDR    = ctrl.gate_mdr;
  assign gateMARMUX = ctrl.gate_marmux;
  assign gateBaseR  = ctrl.gate_baser;
  assign marmux_sel = ctrl.marmux_sel;
  assign memEN      = ctrl.mem_en;
  assign exec_start = ctrl.exec_start;
  assign fault      = ctrl.fault;
  assign state_dbg  = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench: an instruction-level model expands each instruction into the
// per-cycle strobe vectors it must produce; a negedge monitor pops and compares.
module tb_pc_seq_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int BUSY_W      = 3;

  localparam int B_LDMAR = 16, B_LDMDR = 15, B_LDIR = 14, B_LDPC = 13, B_LDR7 = 12;
  localparam int B_GPC = 7, B_GMDR = 6, B_GMARMUX = 5, B_GBASER = 4;
  localparam int B_MMSEL = 3, B_MEMEN = 2, B_XSTART = 1, B_FAULT = 0;

  typedef logic [16:0] vec_t;
  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, run, mem_r, exec_done;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        ldMAR, ldMDR, ldIR, ldPC, ldR7;
  logic [1:0]  selPC, addr2_sel;
  logic        gatePC, gateMDR, gateMARMUX, gateBaseR, marmux_sel, memEN, exec_start, fault;
  logic [3:0]  state_dbg;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t act;
  int   n_vec = 0;
  int   n_bad = 0;

  pc_seq_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .BUSY_W(BUSY_W)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .nzp(nzp), .mem_r(mem_r),
    .exec_done(exec_done), .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR), .ldPC(ldPC),
    .ldR7(ldR7), .selPC(selPC), .addr2_sel(addr2_sel), .gatePC(gatePC),
    .gateMDR(gateMDR), .gateMARMUX(gateMARMUX), .gateBaseR(gateBaseR),
    .marmux_sel(marmux_sel), .memEN(memEN), .exec_start(exec_start),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      act = {ldMAR, ldMDR, ldIR, ldPC, ldR7, selPC, addr2_sel, gatePC, gateMDR,
             gateMARMUX, gateBaseR, marmux_sel, memEN, exec_start, fault};
      n_vec++;
      if (act !== mon_e.v) begin
        n_bad++;
        $display("FAIL %s @%0t: strobes got %h expected %h", mon_e.tag, $time, act, mon_e.v);
      end
    end
  end

  function automatic vec_t b(input int p);
    return vec_t'(1) << p;
  endfunction

  function automatic vec_t spc(input logic [1:0] s);
    return vec_t'(s) << 10;
  endfunction

  function automatic vec_t sa2(input logic [1:0] s);
    return vec_t'(s) << 8;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  // One clock of stimulus; the expected strobes for this cycle go to the scoreboard.
  task automatic step(input logic rst_v, input logic run_v, input logic mr_v,
                      input logic done_v, input vec_t exp_v, input string tag);
    exp_t e;
    reset     = rst_v;
    run       = run_v;
    mem_r     = mr_v;
    exec_done = done_v;
    e.v   = exp_v;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int wf);
    step(1'b1, 1'b1, rb(), rb(), b(B_GPC) | b(B_LDMAR) | b(B_LDPC) | spc(2'b00), "fetch1");
    for (int k = 0; k < wf; k++) step(1'b1, rb(), 1'b0, rb(), b(B_MEMEN), "fetch2_wait");
    step(1'b1, rb(), 1'b1, rb(), b(B_MEMEN) | b(B_LDMDR), "fetch2_rdy");
    step(1'b1, rb(), rb(), rb(), b(B_GMDR) | b(B_LDIR), "fetch3");
  endtask

  // Expected behaviour of one whole instruction, written from the opcode rules.
  task automatic do_instr(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                          input int idle, input int wf, input int wt, input int dx);
    logic [3:0] op;
    logic       ben;
    op  = ir_v[15:12];
    ben = |(ir_v[11:9] & nzp_v);
    ir  = ir_v;
    nzp = nzp_v;
    $display("instr ir=%h nzp=%b idle=%0d wf=%0d wt=%0d dx=%0d", ir_v, nzp_v, idle, wf, wt, dx);
    for (int k = 0; k < idle; k++) step(1'b1, 1'b0, rb(), rb(), '0, "idle");
    fetch(wf);
    step(1'b1, rb(), rb(), rb(), '0, "decode");
    case (op)
      4'b0000: step(1'b1, rb(), rb(), rb(),
                    ben ? (b(B_LDPC) | spc(2'b01) | sa2(2'b00)) : '0, "br");
      4'b1100: step(1'b1, rb(), rb(), rb(), b(B_GBASER) | b(B_LDPC) | spc(2'b10), "jmp");
      4'b0100: begin
        step(1'b1, rb(), rb(), rb(), b(B_GPC) | b(B_LDR7), "jsr");
        if (ir_v[11])
          step(1'b1, rb(), rb(), rb(), b(B_LDPC) | spc(2'b01) | sa2(2'b01), "jsr2_off11");
        else
          step(1'b1, rb(), rb(), rb(), b(B_GBASER) | b(B_LDPC) | spc(2'b10) | sa2(2'b10), "jsrr");
      end
      4'b1111: begin
        step(1'b1, rb(), rb(), rb(), b(B_GMARMUX) | b(B_MMSEL) | b(B_LDMAR), "trap1");
        step(1'b1, rb(), rb(), rb(), b(B_GPC) | b(B_LDR7), "trap2");
        for (int k = 0; k < wt; k++) step(1'b1, rb(), 1'b0, rb(), b(B_MEMEN), "trap3_wait");
        step(1'b1, rb(), 1'b1, rb(), b(B_MEMEN) | b(B_LDMDR), "trap3_rdy");
        step(1'b1, rb(), rb(), rb(), b(B_GMDR) | b(B_LDPC) | spc(2'b10), "trap4");
      end
      default: begin
        for (int k = 0; k <= dx; k++)
          step(1'b1, rb(), rb(), (k == dx), (k == 0) ? b(B_XSTART) : '0, "exec");
      end
    endcase
  endtask

  initial begin
    logic [15:0] r_ir;
    logic [3:0]  ops [8];
    ops = '{4'b0000, 4'b1100, 4'b0100, 4'b1111, 4'b0001, 4'b0101, 4'b0110, 4'b1000};
    reset = 1'b0; run = 1'b1; mem_r = 1'b0; exec_done = 1'b0; ir = 16'h0; nzp = 3'b000;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, rb(), rb(), '0, "in_reset");
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, rb(), rb(), '0, "idle_after_reset");

    do_instr(16'h1021, 3'b000, 0, 3, 0, 2);
    do_instr(16'h0A05, 3'b010, 1, 0, 0, 0);
    do_instr(16'h0A05, 3'b100, 0, 1, 0, 0);
    do_instr(16'h0005, 3'b111, 0, 0, 0, 0);
    do_instr(16'h4805, 3'b001, 0, 2, 0, 0);
    do_instr(16'h4080, 3'b001, 0, 0, 0, 0);
    do_instr(16'hF025, 3'b010, 2, 0, 3, 0);
    do_instr(16'hC1C0, 3'b000, 0, 0, 0, 0);
    do_instr(16'h5020, 3'b000, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r_ir = 16'($urandom);
      r_ir[15:12] = ops[$urandom_range(7, 0)];
      do_instr(r_ir, 3'($urandom), $urandom_range(2, 0), $urandom_range(3, 0),
               $urandom_range(3, 0), $urandom_range(3, 0));
    end

    $display("abort: reset asserted in fetch3");
    ir = 16'h1021;
    step(1'b1, 1'b1, 1'b0, 1'b0, b(B_GPC) | b(B_LDMAR) | b(B_LDPC), "fetch1");
    step(1'b1, 1'b1, 1'b1, 1'b0, b(B_MEMEN) | b(B_LDMDR), "fetch2_rdy");
    step(1'b0, 1'b1, 1'b1, 1'b1, '0, "reset_mid");
    step(1'b0, 1'b1, 1'b1, 1'b1, '0, "reset_mid");
    step(1'b1, 1'b0, 1'b1, 1'b1, '0, "idle_after_abort");
    do_instr(16'h0E01, 3'b001, 0, 0, 0, 0);

    $display("timeout: mem_r held low in fetch2");
    step(1'b1, 1'b1, 1'b0, 1'b0, b(B_GPC) | b(B_LDMAR) | b(B_LDPC), "fetch1");
    for (int k = 0; k < MEM_TIMEOUT; k++) step(1'b1, 1'b1, 1'b0, 1'b0, b(B_MEMEN), "fetch2_wait");
    for (int k = 0; k < 6; k++) step(1'b1, rb(), rb(), rb(), b(B_FAULT), "fault_sticky");
    step(1'b0, 1'b1, 1'b1, 1'b1, '0, "reset_fault");
    step(1'b0, 1'b1, 1'b1, 1'b1, '0, "reset_fault");
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, "idle_after_fault");
    do_instr(16'h1021, 3'b000, 1, 1, 0, 1);

    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
